// File: rtl/arith_pkg.sv
// Shared arithmetic package: FSM state type and counter sizing helper
// for the digit-serial arithmetic blocks.
package arith_pkg;

  // Operating states of the serial subtractor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Width of a counter indexing n digits; never narrower than one bit so
  // the degenerate single-digit case still has a legal counter.
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/sub_digit.sv
// One digit of unsigned subtraction with borrow in and borrow out.
// The borrow out is the MSB of a one-bit-wider difference.
module sub_digit #(
  parameter int DIGIT_WIDTH = 4
) (
  input  logic [DIGIT_WIDTH-1:0] a_dig,
  input  logic [DIGIT_WIDTH-1:0] b_dig,
  input  logic                   bi,
  output logic [DIGIT_WIDTH-1:0] d,
  output logic                   bo
);

  logic [DIGIT_WIDTH:0] res_s;

  // Widened difference; a negative result wraps and sets the top bit.
  always_comb begin
    res_s = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT_WIDTH{1'b0}}, bi};
  end

  assign d  = res_s[DIGIT_WIDTH-1:0];
  assign bo = res_s[DIGIT_WIDTH];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: diff = a - b - borrow_in modulo
// 2^DATA_WIDTH, one DIGIT_WIDTH-bit digit per clock, LSB digit first.
// Operands are captured on an in_valid/in_ready handshake, the result is
// presented on an out_valid/out_ready handshake.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  borrow_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] diff,
  output logic                  borrow_out,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int N     = DATA_WIDTH / DIGIT_WIDTH;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  if ((DATA_WIDTH % DIGIT_WIDTH) != 0) begin : g_bad_width
    $error("serial_subtractor: DATA_WIDTH must be a multiple of DIGIT_WIDTH");
  end

  sub_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  a_q, a_d;
  logic [DATA_WIDTH-1:0]  b_q, b_d;
  logic                   borrow_q, borrow_d;
  logic [DATA_WIDTH-1:0]  diff_q, diff_d;
  logic                   borrow_out_q, borrow_out_d;
  logic                   out_valid_q, out_valid_d;

  logic [DIGIT_WIDTH-1:0] dig_s;
  logic                   dig_bo_s;
  logic                   accept_s;
  logic [DATA_WIDTH+DIGIT_WIDTH-1:0] diff_cat_s;
  logic [DATA_WIDTH-1:0]  diff_shift_s;

  // The single digit cell always works on the low digit of the operand
  // shift registers and the running borrow.
  sub_digit #(
    .DIGIT_WIDTH (DIGIT_WIDTH)
  ) u_sub_digit (
    .a_dig (a_q[DIGIT_WIDTH-1:0]),
    .b_dig (b_q[DIGIT_WIDTH-1:0]),
    .bi    (borrow_q),
    .d     (dig_s),
    .bo    (dig_bo_s)
  );

  assign in_ready = (state_q == IDLE);
  assign accept_s = in_valid && in_ready;

  // New digit enters at the top of the result register; after N shifts
  // digit k has landed in position k.
  always_comb begin
    diff_cat_s   = {dig_s, diff_q};
    diff_shift_s = DATA_WIDTH'(diff_cat_s >> DIGIT_WIDTH);
  end

  // Next-state and datapath update for the IDLE / RUN / DONE sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    borrow_d     = borrow_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    out_valid_d  = out_valid_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          a_d      = a;
          b_d      = b;
          borrow_d = borrow_in;
          cnt_d    = {CNT_W{1'b0}};
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end

      RUN: begin
        a_d      = a_q >> DIGIT_WIDTH;
        b_d      = b_q >> DIGIT_WIDTH;
        borrow_d = dig_bo_s;
        diff_d   = diff_shift_s;
        if (cnt_q == LAST_CNT) begin
          cnt_d        = {CNT_W{1'b0}};
          borrow_out_d = dig_bo_s;
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d        = cnt_q + CNT_W'(1);
          state_d      = RUN;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        cnt_d       = {CNT_W{1'b0}};
        state_d     = IDLE;
      end
    endcase
  end

  // All state, operand, and output registers; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      a_q          <= {DATA_WIDTH{1'b0}};
      b_q          <= {DATA_WIDTH{1'b0}};
      borrow_q     <= 1'b0;
      diff_q       <= {DATA_WIDTH{1'b0}};
      borrow_out_q <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      borrow_q     <= borrow_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (16-bit operands, 4-bit digits).
module tb_serial_subtractor;

  localparam int DW = 16;
  localparam int DG = 4;
  localparam int N  = DW / DG;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] a, b;
  logic          borrow_in;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] diff;
  logic          borrow_out;
  logic          out_valid;
  logic          out_ready;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  serial_subtractor #(.DATA_WIDTH(DW), .DIGIT_WIDTH(DG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to measure issue intervals.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: whole-word subtraction in DW+1 bits; top bit is the borrow.
  function automatic logic [DW:0] ref_sub(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                          input logic bi);
    return {1'b0, x} - {1'b0, y} - {{DW{1'b0}}, bi};
  endfunction

  // Drive one operation through both handshakes; called #1 after a rising edge.
  task automatic run_op(input logic [DW-1:0] a_i, input logic [DW-1:0] b_i, input logic bi_i,
                        input int stall, output logic [DW-1:0] d_o, output logic bo_o,
                        output int lat_o, output int acc_o);
    int w;
    a = a_i; b = b_i; borrow_in = bi_i; in_valid = 1'b1; out_ready = 1'b0;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    acc_o = cyc;
    in_valid = 1'b0;
    a = DW'($urandom); b = DW'($urandom); borrow_in = 1'($urandom);
    lat_o = 0;
    while (out_valid !== 1'b1 && lat_o < 20) begin
      @(posedge clk); #1; lat_o++;
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
    end
    d_o = diff; bo_o = borrow_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a = '0; b = '0; borrow_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 16'h0000 || borrow_out !== 1'b0)
      $display("FAIL reset_state: in_ready=%b out_valid=%b diff=%h borrow_out=%b, want 1 0 0000 0",
               in_ready, out_valid, diff, borrow_out);
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [DW-1:0] va [5] = '{16'd10, 16'd0, 16'h8000, 16'd5, 16'hFFFF};
    logic [DW-1:0] vb [5] = '{16'd3,  16'd1, 16'd1,    16'd5, 16'd0};
    logic          vi [5] = '{1'b0,   1'b0,  1'b1,     1'b1,  1'b0};
    logic [DW-1:0] ed [5] = '{16'd7,  16'hFFFF, 16'h7FFE, 16'hFFFF, 16'hFFFF};
    logic          eb [5] = '{1'b0,   1'b1,  1'b0,     1'b1,  1'b0};
    logic [DW-1:0] d; logic bo; int lat, acc;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vi[i], 0, d, bo, lat, acc);
      total_cnt++;
      if (d !== ed[i] || bo !== eb[i])
        $display("FAIL directed_%0d: diff=%h borrow_out=%b, want %h %b", i, d, bo, ed[i], eb[i]);
      else pass_cnt++;
      total_cnt++;
      if (lat !== N)
        $display("FAIL latency_%0d: out_valid after %0d edges, want %0d", i, lat, N);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    logic [DW:0] exp;
    int w;
    logic ok;
    exp = ref_sub(16'h1234, 16'h0FF0, 1'b1);
    a = 16'h1234; b = 16'h0FF0; borrow_in = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 16'h0001; b = 16'h0002; borrow_in = 1'b0;  // new operands held valid, must be ignored
    w = 0;
    while (out_valid !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    ok = 1'b1;
    for (int s = 0; s < 3; s++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== exp[DW-1:0] || borrow_out !== exp[DW])
        ok = 1'b0;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (!ok || out_valid !== 1'b1 || diff !== exp[DW-1:0])
      $display("FAIL stall_hold: out_valid=%b in_ready=%b diff=%h, want 1 0 %h",
               out_valid, in_ready, diff, exp[DW-1:0]);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL stall_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL stall_no_reaccept: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    logic [DW-1:0] d; logic bo; int lat, acc;
    logic seen;
    a = 16'h1234; b = 16'h0101; borrow_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || diff !== 16'h0000 || in_ready !== 1'b1)
      $display("FAIL reset_mid_run: out_valid=%b diff=%h in_ready=%b, want 0 0000 1",
               out_valid, diff, in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int s = 0; s < 6; s++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (seen)
      $display("FAIL reset_abort: result or busy seen after reset, out_valid=%b in_ready=%b",
               out_valid, in_ready);
    else pass_cnt++;
    run_op(16'd100, 16'd40, 1'b0, 0, d, bo, lat, acc);
    total_cnt++;
    if (d !== 16'd60 || bo !== 1'b0 || lat !== N)
      $display("FAIL post_reset_op: diff=%0d borrow_out=%b lat=%0d, want 60 0 %0d", d, bo, lat, N);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d; logic bo; int lat, acc1, acc2;
    run_op(16'h00FF, 16'h0100, 1'b0, 0, d, bo, lat, acc1);
    total_cnt++;
    if (d !== 16'hFFFF || bo !== 1'b1)
      $display("FAIL b2b_first: diff=%h borrow_out=%b, want ffff 1", d, bo);
    else pass_cnt++;
    run_op(16'hABCD, 16'h1234, 1'b1, 0, d, bo, lat, acc2);
    total_cnt++;
    if (d !== 16'h9998 || bo !== 1'b0)
      $display("FAIL b2b_second: diff=%h borrow_out=%b, want 9998 0", d, bo);
    else pass_cnt++;
    total_cnt++;
    if ((acc2 - acc1) !== N + 2)
      $display("FAIL issue_interval: %0d cycles, want %0d", acc2 - acc1, N + 2);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [DW-1:0] ra, rb, d; logic ri, bo; logic [DW:0] exp; int lat, acc;
    for (int i = 0; i < 40; i++) begin
      ra = DW'($urandom); rb = DW'($urandom); ri = 1'($urandom);
      if (i % 8 == 0) rb = ra;  // exercise exact-equality boundary
      exp = ref_sub(ra, rb, ri);
      run_op(ra, rb, ri, $urandom_range(0, 2), d, bo, lat, acc);
      total_cnt++;
      if (d !== exp[DW-1:0] || bo !== exp[DW] || lat !== N)
        $display("FAIL random_%0d: %h-%h-%b gave diff=%h borrow_out=%b lat=%0d, want %h %b %0d",
                 i, ra, rb, ri, d, bo, lat, exp[DW-1:0], exp[DW], N);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
